// File: rtl/audio_level_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Brief    : Shared widths, default level thresholds, sequencer state
//            encoding and a small helper for the audio level datapath.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents:
//   LEVEL_W / MIC_W / LEVEL_MAX  - level and sample widths, top level value
//   T1_DEFAULT .. T5_DEFAULT     - default peak thresholds for levels 1..5
//   state_e                      - window sequencer states (ACCUM, EVAL)
//   sample_max()                 - unsigned max of two mic samples
// ============================================================================
package audio_pkg;

    localparam int LEVEL_W   = 3;
    localparam int MIC_W     = 12;
    localparam int LEVEL_MAX = 5;

    localparam int T1_DEFAULT = 2200;
    localparam int T2_DEFAULT = 2400;
    localparam int T3_DEFAULT = 2600;
    localparam int T4_DEFAULT = 2800;
    localparam int T5_DEFAULT = 3000;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EVAL  = 1'b1
    } state_e;

    function automatic logic [MIC_W-1:0] sample_max(
        input logic [MIC_W-1:0] a,
        input logic [MIC_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : level_quantizer
// Brief    : Purely combinational peak-to-level compare chain. Returns the
//            highest k in 1..5 with i_peak >= Tk, or 0 below T1. Also used
//            by the display path for an instantaneous readout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_peak   in   MIC_W    unsigned peak value
//   o_level  out  LEVEL_W  quantized level 0..LEVEL_MAX
// ============================================================================
module level_quantizer
    import audio_pkg::*;
#(
    parameter int T1 = T1_DEFAULT,
    parameter int T2 = T2_DEFAULT,
    parameter int T3 = T3_DEFAULT,
    parameter int T4 = T4_DEFAULT,
    parameter int T5 = T5_DEFAULT
) (
    input  logic [MIC_W-1:0]   i_peak,
    output logic [LEVEL_W-1:0] o_level
);

    localparam logic [MIC_W-1:0] C_T1 = MIC_W'(T1);
    localparam logic [MIC_W-1:0] C_T2 = MIC_W'(T2);
    localparam logic [MIC_W-1:0] C_T3 = MIC_W'(T3);
    localparam logic [MIC_W-1:0] C_T4 = MIC_W'(T4);
    localparam logic [MIC_W-1:0] C_T5 = MIC_W'(T5);

    // Thresholds are strictly increasing, so testing from the top down
    // yields the highest satisfied threshold.
    always_comb begin
        o_level = '0;
        if (i_peak >= C_T5) begin
            o_level = LEVEL_W'(LEVEL_MAX);
        end else if (i_peak >= C_T4) begin
            o_level = LEVEL_W'(4);
        end else if (i_peak >= C_T3) begin
            o_level = LEVEL_W'(3);
        end else if (i_peak >= C_T2) begin
            o_level = LEVEL_W'(2);
        end else if (i_peak >= C_T1) begin
            o_level = LEVEL_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : audio_level_ctrl
// Brief    : Windowed peak detector and level sequencer for the microphone
//            datapath. Tracks the peak over WINDOW_SAMPLES accepted samples,
//            quantizes it to a level 0..5 with instant attack and stepped
//            decay, and drives the level display.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLOCK         in   1   system clock, rising edge
//   RESET         in   1   synchronous active-high reset
//   sample_valid  in   1   one-cycle strobe qualifying mic_in
//   mic_in        in   12  unsigned mic sample
//   freeze        in   1   hold level output; windows keep running
//   level         out  3   current volume level 0..5, registered
//   level_update  out  1   one-cycle pulse whenever level is (re)written
//   peak_out      out  12  peak of the last completed window, registered
// ============================================================================
module audio_level_ctrl
    import audio_pkg::*;
#(
    parameter int WINDOW_SAMPLES = 4000,
    parameter int DECAY_WINDOWS  = 2,
    parameter int T1             = T1_DEFAULT,
    parameter int T2             = T2_DEFAULT,
    parameter int T3             = T3_DEFAULT,
    parameter int T4             = T4_DEFAULT,
    parameter int T5             = T5_DEFAULT
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               sample_valid,
    input  logic [MIC_W-1:0]   mic_in,
    input  logic               freeze,
    output logic [LEVEL_W-1:0] level,
    output logic               level_update,
    output logic [MIC_W-1:0]   peak_out
);

    localparam int CNT_W = $clog2(WINDOW_SAMPLES + 1);
    // Decay counter only ever holds 0..DECAY_WINDOWS-1.
    localparam int DEC_W = (DECAY_WINDOWS > 1) ? $clog2(DECAY_WINDOWS) : 1;

    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(WINDOW_SAMPLES - 1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);
    localparam logic [DEC_W-1:0]   C_DEC_LAST = DEC_W'(DECAY_WINDOWS - 1);
    localparam logic [DEC_W-1:0]   C_DEC_ONE  = DEC_W'(1);
    localparam logic [LEVEL_W-1:0] C_LVL_ONE  = LEVEL_W'(1);

    state_e             r_state_q;
    state_e             w_state_d;
    logic [MIC_W-1:0]   r_peak_q;
    logic [MIC_W-1:0]   w_peak_d;
    logic [CNT_W-1:0]   r_cnt_q;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [DEC_W-1:0]   r_dec_q;
    logic [DEC_W-1:0]   w_dec_d;
    logic [LEVEL_W-1:0] r_level_q;
    logic [LEVEL_W-1:0] w_level_d;
    logic               r_level_update_q;
    logic               w_level_update_d;
    logic [MIC_W-1:0]   r_peak_out_q;
    logic [MIC_W-1:0]   w_peak_out_d;

    logic [LEVEL_W-1:0] w_win_level;

    level_quantizer #(
        .T1 (T1),
        .T2 (T2),
        .T3 (T3),
        .T4 (T4),
        .T5 (T5)
    ) u_quantizer (
        .i_peak  (r_peak_q),
        .o_level (w_win_level)
    );

    always_comb begin
        w_state_d        = r_state_q;
        w_peak_d         = r_peak_q;
        w_cnt_d          = r_cnt_q;
        w_dec_d          = r_dec_q;
        w_level_d        = r_level_q;
        w_level_update_d = 1'b0;
        w_peak_out_d     = r_peak_out_q;

        case (r_state_q)
            ACCUM: begin
                if (sample_valid) begin
                    w_peak_d = sample_max(r_peak_q, mic_in);
                    w_cnt_d  = r_cnt_q + C_CNT_ONE;
                    if (r_cnt_q == C_CNT_LAST) begin
                        w_state_d = EVAL;
                    end
                end
            end

            EVAL: begin
                w_state_d    = ACCUM;
                w_peak_out_d = r_peak_q;

                // A sample arriving during evaluation opens the next window
                // so that no sample is ever dropped.
                if (sample_valid) begin
                    w_peak_d = mic_in;
                    w_cnt_d  = C_CNT_ONE;
                end else begin
                    w_peak_d = '0;
                    w_cnt_d  = '0;
                end

                if (!freeze) begin
                    w_level_update_d = 1'b1;
                    if (w_win_level >= r_level_q) begin
                        // Instant attack (or hold at the same level).
                        w_level_d = w_win_level;
                        w_dec_d   = '0;
                    end else if (r_dec_q == C_DEC_LAST) begin
                        // Enough quieter windows: step down by exactly one.
                        // wl < level guarantees level-1 >= wl.
                        w_level_d = r_level_q - C_LVL_ONE;
                        w_dec_d   = '0;
                    end else begin
                        w_dec_d = r_dec_q + C_DEC_ONE;
                    end
                end
            end

            default: begin
                w_state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state_q        <= ACCUM;
            r_peak_q         <= '0;
            r_cnt_q          <= '0;
            r_dec_q          <= '0;
            r_level_q        <= '0;
            r_level_update_q <= 1'b0;
            r_peak_out_q     <= '0;
        end else begin
            r_state_q        <= w_state_d;
            r_peak_q         <= w_peak_d;
            r_cnt_q          <= w_cnt_d;
            r_dec_q          <= w_dec_d;
            r_level_q        <= w_level_d;
            r_level_update_q <= w_level_update_d;
            r_peak_out_q     <= w_peak_out_d;
        end
    end

    assign level        = r_level_q;
    assign level_update = r_level_update_q;
    assign peak_out     = r_peak_out_q;

endmodule
`default_nettype wire
